// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM; `MULTICYCLE_CONTROL_BNE_EN adds the bne state and pcWriteCondNot.
// Outputs registered from next state; FETCH and memory states stall while memReady is low.
module multicycle_control #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                memReady,
  output logic                pcWrite,
  output logic                pcWriteCond,
`ifdef MULTICYCLE_CONTROL_BNE_EN
  output logic                pcWriteCondNot,
`endif
  output logic                iorD,
  output logic                memRead,
  output logic                memWrite,
  output logic                irWrite,
  output logic                memToReg,
  output logic                regDst,
  output logic                regWrite,
  output logic                aluSrcA,
  output logic [1:0]          aluSrcB,
  output logic [ALUOP_W-1:0]  aluOp,
  output logic [1:0]          pcSrc,
  output logic                halted,
  output logic                illegal,
  output logic [STATE_W-1:0]  state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    MEMADR = STATE_W'(2),
    MEMRD  = STATE_W'(3),
    MEMWB  = STATE_W'(4),
    MEMWR  = STATE_W'(5),
    EXEC   = STATE_W'(6),
    ALUWB  = STATE_W'(7),
    BRANCH = STATE_W'(8),
    ADDIEX = STATE_W'(9),
    ADDIWB = STATE_W'(10),
    JUMP   = STATE_W'(11),
`ifdef MULTICYCLE_CONTROL_BNE_EN
    HALT   = STATE_W'(12),
    BNE    = STATE_W'(13)
`else
    HALT   = STATE_W'(12)
`endif
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(6'b111111);
`ifdef MULTICYCLE_CONTROL_BNE_EN
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
`endif

  typedef struct packed {
    logic               pcWrite;
    logic               fetchGate;
    logic               pcWriteCond;
`ifdef MULTICYCLE_CONTROL_BNE_EN
    logic               pcWriteCondNot;
`endif
    logic               iorD;
    logic               memRead;
    logic               memWrite;
    logic               memToReg;
    logic               regDst;
    logic               regWrite;
    logic               aluSrcA;
    logic [1:0]         aluSrcB;
    logic [ALUOP_W-1:0] aluOp;
    logic [1:0]         pcSrc;
    logic               halted;
  } ctrl_t;

  state_t stateReg;
  state_t nextState;
  ctrl_t  ctl;
  logic   illegalReg;
  logic   decodeIllegal;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.memRead = 1'b1; c.aluSrcB = 2'b01; c.fetchGate = 1'b1; end
      DECODE: c.aluSrcB = 2'b11;
      MEMADR: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      MEMRD:  begin c.memRead = 1'b1; c.iorD = 1'b1; end
      MEMWB:  begin c.regWrite = 1'b1; c.memToReg = 1'b1; end
      MEMWR:  begin c.memWrite = 1'b1; c.iorD = 1'b1; end
      EXEC:   begin c.aluSrcA = 1'b1; c.aluOp = ALUOP_W'(2); end
      ALUWB:  begin c.regWrite = 1'b1; c.regDst = 1'b1; end
      BRANCH: begin
        c.aluSrcA = 1'b1; c.aluOp = ALUOP_W'(1); c.pcWriteCond = 1'b1; c.pcSrc = 2'b01;
      end
      ADDIEX: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      ADDIWB: c.regWrite = 1'b1;
      JUMP:   begin c.pcWrite = 1'b1; c.pcSrc = 2'b10; end
      HALT:   c.halted = 1'b1;
`ifdef MULTICYCLE_CONTROL_BNE_EN
      BNE:    begin
        c.aluSrcA = 1'b1; c.aluOp = ALUOP_W'(1); c.pcWriteCondNot = 1'b1; c.pcSrc = 2'b01;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nextState     = FETCH;
    decodeIllegal = 1'b0;
    case (stateReg)
      FETCH:  nextState = memReady ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     nextState = EXEC;
          OP_LW, OP_SW: nextState = MEMADR;
          OP_BEQ:       nextState = BRANCH;
          OP_ADDI:      nextState = ADDIEX;
          OP_J:         nextState = JUMP;
          OP_HALT:      nextState = HALT;
`ifdef MULTICYCLE_CONTROL_BNE_EN
          OP_BNE:       nextState = BNE;
`endif
          default: begin
            nextState     = FETCH;
            decodeIllegal = 1'b1;
          end
        endcase
      end
      // Only lw and sw reach MEMADR, so anything but sw is a load.
      MEMADR: nextState = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  nextState = memReady ? MEMWB : MEMRD;
      MEMWB:  nextState = FETCH;
      MEMWR:  nextState = memReady ? FETCH : MEMWR;
      EXEC:   nextState = ALUWB;
      ALUWB:  nextState = FETCH;
      BRANCH: nextState = FETCH;
      ADDIEX: nextState = ADDIWB;
      ADDIWB: nextState = FETCH;
      JUMP:   nextState = FETCH;
      HALT:   nextState = HALT;
      default: nextState = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= FETCH;
      ctl        <= decode(FETCH);
      illegalReg <= 1'b0;
    end else begin
      stateReg   <= nextState;
      ctl        <= decode(nextState);
      illegalReg <= decodeIllegal;
    end
  end

  // FETCH's IR/PC load is the one place the memory handshake gates an output directly.
  assign irWrite     = ctl.fetchGate & memReady;
  assign pcWrite     = ctl.pcWrite | (ctl.fetchGate & memReady);
  assign pcWriteCond = ctl.pcWriteCond;
`ifdef MULTICYCLE_CONTROL_BNE_EN
  assign pcWriteCondNot = ctl.pcWriteCondNot;
`endif
  assign iorD     = ctl.iorD;
  assign memRead  = ctl.memRead;
  assign memWrite = ctl.memWrite;
  assign memToReg = ctl.memToReg;
  assign regDst   = ctl.regDst;
  assign regWrite = ctl.regWrite;
  assign aluSrcA  = ctl.aluSrcA;
  assign aluSrcB  = ctl.aluSrcB;
  assign aluOp    = ctl.aluOp;
  assign pcSrc    = ctl.pcSrc;
  assign halted   = ctl.halted;
  assign illegal  = illegalReg;
  assign state    = stateReg;

endmodule
